if_fetch_stage: RTL

- Instruction-fetch stage with the IF/ID pipeline register.
- Holds the PC and drives a single-outstanding request/ready interface to instruction memory.
- Presents the fetched instruction and PC+4 to decode. id_inst[15:0] feeds the decode-stage sign extender directly.
- Handles decode stalls without losing fetched words, and branch/jump redirects, including a redirect that arrives while a fetch is still pending.

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/if_id_reg.sv | 40 ++++
 rtl/if_fetch_stage.sv | 129 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types and constants: fetch FSM states, pipeline register
// control and the IF/ID payload with its bubble/reset value.
package cpu_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0000;
   localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

   typedef enum logic [1:0] {
      FS_RUN   = 2'd0,
      FS_HOLD  = 2'd1,
      FS_DRAIN = 2'd2
   } fetch_state_e;

   typedef enum logic [1:0] {
      PR_HOLD   = 2'd0,
      PR_LOAD   = 2'd1,
      PR_BUBBLE = 2'd2
   } pipe_ctrl_e;

   typedef struct packed {
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] pc_plus4;
      logic            valid;
   } if_id_t;

   localparam if_id_t IF_ID_RESET = '{inst: NOP_INST, pc_plus4: '0, valid: 1'b0};

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold, load and bubble controls; a bubble keeps
// the last pc_plus4 and only kills the instruction.
module if_id_reg
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] BUBBLE_INST = NOP_INST
) (
   input  logic       clk,
   input  logic       rst_n,
   input  pipe_ctrl_e ctrl,
   input  if_id_t     d,
   output if_id_t     q
);

   if_id_t reg_q;
   if_id_t reg_d;

   always_comb begin
      reg_d = reg_q;
      case (ctrl)
         PR_LOAD:   reg_d = d;
         PR_BUBBLE: begin
            reg_d.inst  = BUBBLE_INST;
            reg_d.valid = 1'b0;
         end
         default:   reg_d = reg_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_q <= '{inst: BUBBLE_INST, pc_plus4: '0, valid: 1'b0};
      end else begin
         reg_q <= reg_d;
      end
   end

   assign q = reg_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding imem request, stall hold
// buffer and redirect handling (including redirects while a fetch is pending).
module if_fetch_stage #(
   parameter logic [cpu_pkg::XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [cpu_pkg::XLEN-1:0] NOP_INST = cpu_pkg::NOP_INST
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     stall,
   input  logic                     redirect,
   input  logic [cpu_pkg::XLEN-1:0] redirect_pc,
   output logic                     imem_req,
   output logic [cpu_pkg::XLEN-1:0] imem_addr,
   input  logic                     imem_ready,
   input  logic [cpu_pkg::XLEN-1:0] imem_rdata,
   output logic [cpu_pkg::XLEN-1:0] id_inst,
   output logic [cpu_pkg::XLEN-1:0] id_pc_plus4,
   output logic                     id_valid
);
   import cpu_pkg::*;

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] tgt_q, tgt_d;
   if_id_t          buf_q, buf_d;
   logic            req_q, req_d;

   pipe_ctrl_e      ifid_ctrl;
   if_id_t          ifid_d;
   if_id_t          ifid_q;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] redirect_tgt;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      tgt_d        = tgt_q;
      buf_d        = buf_q;
      ifid_ctrl    = PR_HOLD;
      pc_plus4     = pc_q + PC_STEP;
      redirect_tgt = word_align(redirect_pc);
      ifid_d       = '{inst: imem_rdata, pc_plus4: pc_plus4, valid: 1'b1};

      case (state_q)
         FS_RUN: begin
            if (redirect) begin
               ifid_ctrl = PR_BUBBLE;
               if (imem_ready) begin
                  pc_d = redirect_tgt;
               end else begin
                  tgt_d   = redirect_tgt;
                  state_d = FS_DRAIN;
               end
            end else if (imem_ready) begin
               pc_d = pc_plus4;
               if (stall) begin
                  buf_d   = ifid_d;
                  state_d = FS_HOLD;
               end else begin
                  ifid_ctrl = PR_LOAD;
               end
            end else if (!stall) begin
               ifid_ctrl = PR_BUBBLE;
            end
         end
         FS_HOLD: begin
            if (redirect) begin
               buf_d     = IF_ID_RESET;
               pc_d      = redirect_tgt;
               ifid_ctrl = PR_BUBBLE;
               state_d   = FS_RUN;
            end else if (!stall) begin
               ifid_d    = buf_q;
               ifid_ctrl = PR_LOAD;
               state_d   = FS_RUN;
            end
         end
         FS_DRAIN: begin
            // Pending word belongs to the squashed path; the newest target wins.
            ifid_ctrl = PR_BUBBLE;
            if (redirect) begin
               tgt_d = redirect_tgt;
            end
            if (imem_ready) begin
               pc_d    = redirect ? redirect_tgt : tgt_q;
               state_d = FS_RUN;
            end
         end
         default: begin
            state_d = FS_RUN;
         end
      endcase

      req_d = (state_d != FS_HOLD);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= FS_RUN;
         pc_q    <= RESET_PC;
         tgt_q   <= RESET_PC;
         buf_q   <= IF_ID_RESET;
         req_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
         buf_q   <= buf_d;
         req_q   <= req_d;
      end
   end

   if_id_reg #(
      .BUBBLE_INST(NOP_INST)
   ) u_if_id_reg (
      .clk  (clk),
      .rst_n(reset),
      .ctrl (ifid_ctrl),
      .d    (ifid_d),
      .q    (ifid_q)
   );

   assign imem_req    = req_q;
   assign imem_addr   = pc_q;
   assign id_inst     = ifid_q.inst;
   assign id_pc_plus4 = ifid_q.pc_plus4;
   assign id_valid    = ifid_q.valid;

endmodule
